// File: rtl/trigger_packetizer_pkg.sv
// ============================================================================
// Module      : trigger_packetizer_pkg
// Description : Shared state encoding and constants for trigger_packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trigger_packetizer_pkg;

    localparam int TIMESTAMP_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/trigger_packetizer.sv
// ============================================================================
// Module      : trigger_packetizer
// Description : Forwards cfg_length samples as one AXI-Stream packet after an
//               armed trigger; drops samples otherwise. Optional trigger
//               timestamp under TRIG_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_packetizer
    import trigger_packetizer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        arm,
    input  logic                        trigger,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        done
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [TIMESTAMP_WIDTH-1:0]  trig_timestamp
`endif
);

    localparam logic [CNTR_WIDTH-1:0] c_one  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTR_WIDTH-1:0] c_zero = '0;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNTR_WIDTH-1:0] r_count;
    logic [CNTR_WIDTH-1:0] r_len;
    logic                  w_capture;
    logic                  w_handshake;
    logic                  w_last_beat;
    logic                  w_arm_accept;
    logic                  w_fire;

    always_comb begin
        w_capture     = (r_state == CAPTURE);
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = w_capture & s_axis_tvalid;
        s_axis_tready = w_capture ? m_axis_tready : 1'b1;
        w_handshake   = w_capture & s_axis_tvalid & m_axis_tready;
        w_last_beat   = (r_count == (r_len - c_one));
        m_axis_tlast  = m_axis_tvalid & w_last_beat;
        busy          = (r_state == ARMED) | w_capture;
        done          = (r_state == DONE);
        w_arm_accept  = 1'b0;
        w_fire        = 1'b0;
        w_state_next  = r_state;

        case (r_state)
            IDLE: begin
                if (arm && (cfg_length != c_zero)) begin
                    w_arm_accept = 1'b1;
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                // Abort takes precedence over a coincident trigger.
                if (!arm) begin
                    w_state_next = IDLE;
                end else if (trigger) begin
                    w_fire       = 1'b1;
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_handshake && w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (!arm) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_count <= '0;
            r_len   <= '0;
        end else if (w_arm_accept) begin
            r_count <= '0;
            r_len   <= cfg_length;
        end else if (w_handshake) begin
            r_count <= r_count + c_one;
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TIMESTAMP_WIDTH-1:0] r_cycle;
    logic [TIMESTAMP_WIDTH-1:0] r_trig_ts;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cycle   <= '0;
            r_trig_ts <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_fire) begin
                r_trig_ts <= r_cycle;
            end
        end
    end

    assign trig_timestamp = r_trig_ts;
`endif

endmodule

`default_nettype wire
